// File: rtl/sd_stream_accumulator.sv
// Streaming signed-digit accumulator. Each accepted operand is added carry-free into a redundant sum, and the frame sum is held at the output when in_last arrives.
// Latency: out_valid rises one cycle after the edge that accepts in_last. Backpressure: in_ready is low while a sum is held, and the hold lasts until out_ready.
// Optional macro SD_TO_BIN_EN adds out_bin_o, the two's-complement value of the held sum.
module sd_stream_accumulator #(
    parameter int  WIDTH        = 4,
    parameter int  MAX_OPERANDS = 4,
    localparam int GUARD        = $clog2(MAX_OPERANDS) + 2,
    localparam int AW           = WIDTH + GUARD,
    localparam int CW           = $clog2(MAX_OPERANDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_plus_i,
    input  logic [WIDTH-1:0] in_minus_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [AW-1:0]    out_plus_o,
    output logic [AW-1:0]    out_minus_o,
    output logic [CW-1:0]    out_count_o,
    output logic             out_ovf_o
`ifdef SD_TO_BIN_EN
    ,
    output logic [AW-1:0]    out_bin_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPERANDS);

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_plus_q, acc_plus_d;
    logic [AW-1:0]   acc_minus_q, acc_minus_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic [AW-1:0]   op_plus, op_minus;
    logic [AW-1:0]   sum_plus, sum_minus;
    logic signed [2:0] wx [AW+2];
    logic signed [1:0] dig;

    assign op_plus  = {{GUARD{1'b0}}, in_plus_i};
    assign op_minus = {{GUARD{1'b0}}, in_minus_i};

    // Transfer out of a position with digit sum w; lower_neg is the sign of the
    // position below, which picks the split so the receiving digit stays in range.
    function automatic logic signed [1:0] xfer(input logic signed [2:0] w, input logic lower_neg);
        logic signed [1:0] t;
        t = 2'sd0;
        case (w)
            3'b010: t = 2'sd1;
            3'b110: t = -2'sd1;
            3'b001: t = lower_neg ? 2'sd0 : 2'sd1;
            3'b111: t = lower_neg ? -2'sd1 : 2'sd0;
            default: t = 2'sd0;
        endcase
        return t;
    endfunction

    function automatic logic signed [1:0] interim(input logic signed [2:0] w, input logic lower_neg);
        logic signed [1:0] u;
        u = 2'sd0;
        case (w)
            3'b001, 3'b111: u = lower_neg ? 2'sd1 : -2'sd1;
            default:        u = 2'sd0;
        endcase
        return u;
    endfunction

    // Carry-free add: each result digit sees only digit sums i, i-1 and i-2.
    // Two zero entries at the bottom of wx stand in for positions -1 and -2.
    always_comb begin
        dig       = 2'sd0;
        sum_plus  = '0;
        sum_minus = '0;
        wx[0]     = 3'sd0;
        wx[1]     = 3'sd0;
        for (int i = 0; i < AW; i++) begin
            wx[i+2] = 3'(acc_plus_q[i]) - 3'(acc_minus_q[i]) + 3'(op_plus[i]) - 3'(op_minus[i]);
        end
        for (int i = 0; i < AW; i++) begin
            dig          = interim(wx[i+2], wx[i+1][2]) + xfer(wx[i+1], wx[i][2]);
            sum_plus[i]  = (dig == 2'sd1);
            sum_minus[i] = (dig == -2'sd1);
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_plus_d  = acc_plus_q;
        acc_minus_d = acc_minus_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    acc_plus_d  = sum_plus;
                    acc_minus_d = sum_minus;
                    if (count_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    state_d = in_last_i ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    acc_plus_d  = '0;
                    acc_minus_d = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_plus_q  <= '0;
            acc_minus_q <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_plus_q  <= acc_plus_d;
            acc_minus_q <= acc_minus_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // The accumulator itself is the held result; it only changes on accept or clear.
    assign out_plus_o  = acc_plus_q;
    assign out_minus_o = acc_minus_q;
    assign out_count_o = count_q;
    assign out_ovf_o   = ovf_q;

`ifdef SD_TO_BIN_EN
    assign out_bin_o = acc_plus_q - acc_minus_q;
`endif

endmodule

// File: tb/tb_sd_stream_accumulator.sv
// Directed and randomized frames for sd_stream_accumulator, checked against an integer-sum model.
module tb_sd_stream_accumulator;

    localparam int W  = 4;
    localparam int M  = 4;
    localparam int AW = W + $clog2(M) + 2;
    localparam int CW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_plus;
    logic [W-1:0]  in_minus;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_plus;
    logic [AW-1:0] out_minus;
    logic [CW-1:0] out_count;
    logic          out_ovf;
`ifdef SD_TO_BIN_EN
    logic [AW-1:0] out_bin;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic signed [63:0] exp_sum;
    int                 n_ops;

    always #5 clk = ~clk;

    sd_stream_accumulator #(.WIDTH(W), .MAX_OPERANDS(M)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_plus_i   (in_plus),
        .in_minus_i  (in_minus),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_plus_o  (out_plus),
        .out_minus_o (out_minus),
        .out_count_o (out_count),
        .out_ovf_o   (out_ovf)
`ifdef SD_TO_BIN_EN
        ,
        .out_bin_o   (out_bin)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] sdval(input logic [AW-1:0] p, input logic [AW-1:0] m);
        logic signed [63:0] v;
        v = 0;
        for (int i = 0; i < AW; i++) v = v + (64'(p[i]) - 64'(m[i])) * (64'sd1 <<< i);
        return v;
    endfunction

    // Starts and ends at posedge+1; waits (bounded) for in_ready, then updates the model.
    task automatic send(input logic [W-1:0] p, input logic [W-1:0] m, input logic last);
        logic done;
        done     = 1'b0;
        in_plus  = p;
        in_minus = m;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("accept", done, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_sum  = exp_sum + sdval(AW'(p), AW'(m));
        n_ops++;
    endtask

    task automatic check_result(input string tag);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".count"}, out_count, (n_ops > M) ? M : n_ops);
        chk({tag, ".ovf"}, out_ovf, (n_ops > M) ? 1 : 0);
        if (n_ops <= M) begin
            chk({tag, ".value"}, sdval(out_plus, out_minus), exp_sum);
`ifdef SD_TO_BIN_EN
            chk({tag, ".bin"}, $signed(out_bin), exp_sum);
`endif
        end
    endtask

    // Called right after the last accept: the sum must be valid on the very next cycle.
    task automatic check_frame(input string tag);
        @(negedge clk);
        check_result(tag);
    endtask

    // Holds out_ready low for 'hold' cycles (optionally with in_valid high), then handshakes.
    task automatic release_out(input string tag, input int hold, input logic push);
        in_valid = push;
        in_plus  = 4'b0001;
        in_minus = 4'b0000;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_result({tag, ".hold"});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_sum   = 0;
        n_ops     = 0;
        @(negedge clk);
        chk({tag, ".post_valid"}, out_valid, 0);
        chk({tag, ".post_ready"}, in_ready, 1);
        chk({tag, ".post_count"}, out_count, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [W-1:0] rp, rm;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_plus   = '0;
        in_minus  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        exp_sum   = 0;
        n_ops     = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", out_valid, 0);
        chk("rst.plus", out_plus, 0);
        chk("rst.minus", out_minus, 0);
        chk("rst.count", out_count, 0);
        chk("rst.ovf", out_ovf, 0);
`ifdef SD_TO_BIN_EN
        chk("rst.bin", out_bin, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.in_ready", in_ready, 1);
        chk("rel.valid", out_valid, 0);
        @(posedge clk);
        #1;

        // +5, -3, +7 back to back
        send(4'b0101, 4'b0000, 1'b0);
        send(4'b0000, 4'b0011, 1'b0);
        send(4'b0111, 4'b0000, 1'b1);
        check_frame("f1");
        chk("f1.exp9", exp_sum, 9);
        release_out("f1", 0, 1'b0);

        // (1,1) zero digits, then 8-1 = +7
        send(4'b1111, 4'b1111, 1'b0);
        send(4'b1000, 4'b0001, 1'b1);
        check_frame("f2");
        release_out("f2", 1, 1'b0);

        // four times -15: largest legal magnitude
        for (int k = 0; k < 4; k++) send(4'b0000, 4'b1111, (k == 3));
        check_frame("f3");
        release_out("f3", 0, 1'b0);

        // five operands: overflow, count saturates
        for (int k = 0; k < 5; k++) send(4'b0001, 4'b0000, (k == 4));
        check_frame("f4");
        release_out("f4", 0, 1'b0);

        // single operand with backpressure and in_valid held during DONE
        send(4'b0011, 4'b0000, 1'b1);
        check_frame("f5");
        release_out("f5", 3, 1'b1);
        send(4'b0010, 4'b0000, 1'b1);
        check_frame("f6");
        release_out("f6", 0, 1'b0);

        // reset mid-frame discards the partial sum
        send(4'b0111, 4'b0000, 1'b0);
        send(4'b0110, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mrst.valid", out_valid, 0);
        chk("mrst.count", out_count, 0);
        chk("mrst.value", sdval(out_plus, out_minus), 0);
        exp_sum = 0;
        n_ops   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b0000, 4'b0101, 1'b1);
        check_frame("f7");
        release_out("f7", 0, 1'b0);

        // randomized frames with gaps and output stalls
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                rp = W'($urandom);
                rm = W'($urandom);
                send(rp, rm, (k == n - 1));
            end
            check_frame($sformatf("rnd%0d", f));
            release_out($sformatf("rnd%0d", f), $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sd_stream_accumulator.md
Name: sd_stream_accumulator

Overview:
Streaming multi-operand adder for signed-digit (plus/minus vector) operands. Operands arrive one per cycle on a valid/ready interface and are summed carry-free into a redundant accumulator. A frame ends when an operand arrives with in_last; the frame sum is then presented in signed-digit form on a held output handshake. This block generalises the fixed three-operand signed-digit adder to parametrised width and a variable operand count, with framing, guard digits and overflow detection.

Parameters:
WIDTH, 4, digit count of each input operand
MAX_OPERANDS, 4, maximum operands per frame that are guaranteed to sum without overflow
GUARD (localparam), $clog2(MAX_OPERANDS)+2, extra accumulator digits
AW (localparam), WIDTH+GUARD, accumulator and output digit count
CW (localparam), $clog2(MAX_OPERANDS+1), operand counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept an operand
in_plus  in  WIDTH  positive digit bits of the operand
in_minus  in  WIDTH  negative digit bits of the operand
in_last  in  1  final operand of the frame, qualified by in_valid
out_valid  out  1  frame sum valid
out_ready  in  1  consumer accepts the sum
out_plus  out  AW  positive digit bits of the sum
out_minus  out  AW  negative digit bits of the sum
out_count  out  CW  operands accepted in the frame, saturating at MAX_OPERANDS
out_ovf  out  1  more than MAX_OPERANDS operands were accepted in the frame

Behaviour:
- Digit i value = plus[i] - minus[i], in {-1, 0, +1}. Both encodings (0,0) and (1,1) mean 0 and must be accepted on the input. Operand value = sum of digit_i * 2^i.
- Reset (rst_n low, asynchronous): state is IDLE, accumulator is 0, count is 0, ovf is 0, out_valid is 0, out_plus and out_minus are 0, out_count is 0, out_ovf is 0. After reset release, in_ready is 1. Asserting reset mid-frame discards the partial frame immediately.
- States:
  - IDLE and ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accepting an operand (in_valid & in_ready):
  - The accumulator is replaced by acc + operand in the same edge. The operand is zero-padded to AW digits; no sign extension is needed.
  - The addition is a carry-free signed-digit add. Each result digit depends only on input digits i, i-1 and i-2. There is no ripple carry.
  - count increments; it saturates at MAX_OPERANDS. When count is already MAX_OPERANDS, ovf is set (sticky for the frame).
  - State transitions: IDLE goes to ACCUM. With in_last, the next state is DONE from either IDLE or ACCUM.
- Latency: out_valid rises on the cycle after the edge that accepted the in_last operand. The sum on out_plus/out_minus includes that operand.
- DONE:
  - out_plus, out_minus, out_count and out_ovf are driven from registers and stay stable until out_valid & out_ready.
  - in_valid is ignored in DONE.
  - On the output handshake edge: the accumulator, count and ovf clear, and the state returns to IDLE. in_ready is therefore 1 on the next cycle, giving one bubble between frames.
- A single-operand frame (in_last on the first operand) is legal. Its result equals that operand's value.
- Value rule: with no overflow, the value of out_plus minus out_minus equals the exact signed sum of the frame operands. The digit encoding of the sum is implementation-defined. The bench checks value only.
- With ovf=1, the sum value is undefined. out_count reads MAX_OPERANDS.

Optional Feature:
SD_TO_BIN_EN:
- Defined: adds port out_bin (output, AW bits), the two's-complement value of out_plus minus out_minus. It is computed combinationally from the output registers and is valid whenever out_valid=1. It reads 0 during reset.
- Undefined: port out_bin and its subtractor are absent. Nothing else changes.

Test Plan:
- Reset, then release: in_ready=1, out_valid=0, out_plus=out_minus=0, out_count=0, out_ovf=0.
- WIDTH=4: send 0101/0000 (+5), 0000/0011 (-3), 0111/0000 (+7, in_last) on consecutive cycles -> out_valid on the next cycle, value +9, out_count=3, out_ovf=0.
- Send 1111/1111 (0) then 1000/0001 (+7, in_last) -> value +7, out_count=2, out_bin=00000111 when SD_TO_BIN_EN is defined.
- Send four operands of 0000/1111 (-15), last on the fourth -> value -60, out_count=4, out_ovf=0.
- Send five operands of 0001/0000, last on the fifth -> out_ovf=1, out_count=4.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no operand consumed; raise out_ready -> IDLE on the next cycle. Separately, pulse rst_n low mid-frame -> out_valid=0, and the next frame's sum excludes the earlier operands.
